// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: sequencer states,
// opcode field bounds and the opcode constants that matter to fetch.
package instruction_fetch_controller_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   localparam logic [5:0] HALT_OPCODE = 6'b111111;
   localparam logic [5:0] OP_ADD      = 6'b000000;
   localparam logic [5:0] OP_SUB      = 6'b000010;
   localparam logic [5:0] OP_SUBI     = 6'b000011;

endpackage

// File: rtl/instruction_fetch_controller.sv
// Owns the program counter: lets a host load the instruction RAM, then streams
// fetched words to decode over a valid/ready handshake until a HALT opcode.
module instruction_fetch_controller #(
   parameter int         ADDR_WIDTH  = 10,
   parameter int         DATA_WIDTH  = 32,
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_valid,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_done,
   output logic [ADDR_WIDTH-1:0] iram_address,
   output logic                  iram_write_enable,
   output logic [DATA_WIDTH-1:0] iram_write_data,
   input  logic [DATA_WIDTH-1:0] iram_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  halted
);

   import instruction_fetch_controller_pkg::*;

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next;
   logic                  valid_next;
   logic [DATA_WIDTH-1:0] data_next;
   logic [ADDR_WIDTH-1:0] instr_pc_next;
   logic                  redirect;
   logic                  fetch;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= LOAD;
         pc          <= '0;
         instr_valid <= 1'b0;
         instr_data  <= '0;
         instr_pc    <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr_valid <= valid_next;
         instr_data  <= data_next;
         instr_pc    <= instr_pc_next;
      end
   end

   // A redirect beats everything, including a same-cycle accept of the held word.
   always_comb begin
      state_next        = state;
      pc_next           = pc;
      valid_next        = instr_valid;
      data_next         = instr_data;
      instr_pc_next     = instr_pc;
      iram_address      = pc;
      iram_write_enable = 1'b0;
      iram_write_data   = load_data;
      halted            = 1'b0;
      redirect          = branch_valid && ((state == RUN) || (state == DRAIN));
      fetch             = (state == RUN) && (!instr_valid || instr_ready) && !branch_valid;

      case (state)
         LOAD: begin
            iram_address      = load_addr;
            iram_write_enable = load_valid;
            valid_next        = 1'b0;
            if (load_done) begin
               state_next = RUN;
               pc_next    = '0;
            end
         end
         RUN: begin
            if (redirect) begin
               pc_next    = branch_target;
               valid_next = 1'b0;
            end else if (fetch) begin
               data_next     = iram_data;
               instr_pc_next = pc;
               valid_next    = 1'b1;
               if (iram_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                  state_next = DRAIN;
               end else begin
                  pc_next = pc + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (redirect) begin
               pc_next    = branch_target;
               valid_next = 1'b0;
               state_next = RUN;
            end else if (instr_ready) begin
               valid_next = 1'b0;
               state_next = HALT;
            end
         end
         HALT: begin
            halted     = 1'b1;
            valid_next = 1'b0;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: RAM beside the DUT, a transaction-level model of which
// word must be delivered next, directed scenarios plus a randomized run.
`timescale 1ns/1ps
module tb_instruction_fetch_controller;
   import instruction_fetch_controller_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          load_valid = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [DW-1:0] load_data = '0;
   logic          load_done = 1'b0;
   logic [AW-1:0] iram_address;
   logic          iram_write_enable;
   logic [DW-1:0] iram_write_data;
   logic [DW-1:0] iram_data;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          branch_valid = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          halted;

   logic [DW-1:0] ram      [0:1023];
   logic [DW-1:0] memModel [0:1023];

   int            errors = 0;
   int            checks = 0;
   logic [AW-1:0] expPc;
   bit            expHalted;
   bit            prevHold;
   logic [DW-1:0] prevData;
   logic [AW-1:0] prevPc;
   int            gap;
   int            deliveredQ[$];
   int            expectQ[$];

   instruction_fetch_controller dut (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .iram_address(iram_address), .iram_write_enable(iram_write_enable),
      .iram_write_data(iram_write_data), .iram_data(iram_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .halted(halted)
   );

   always #5 clock = ~clock;

   // Instruction RAM: combinational read, write on the rising edge.
   assign iram_data = ram[iram_address];
   always @(posedge clock) begin
      if (iram_write_enable) ram[iram_address] = iram_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] randNonHalt();
      logic [DW-1:0] w;
      logic [5:0]    ops [3];
      ops[0] = OP_ADD;
      ops[1] = OP_SUB;
      ops[2] = OP_SUBI;
      w = $urandom;
      w[31:26] = ops[$urandom % 3];
      return w;
   endfunction

   function automatic logic [DW-1:0] haltWord();
      logic [DW-1:0] w;
      w = $urandom;
      w[31:26] = HALT_OPCODE;
      return w;
   endfunction

   task automatic resetModel();
      expPc     = '0;
      expHalted = 1'b0;
      prevHold  = 1'b0;
      gap       = 0;
      deliveredQ.delete();
   endtask

   // One host write; load_done on the same cycle still commits the write.
   task automatic loadWord(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit done);
      load_valid    = 1'b1;
      load_addr     = addr;
      load_data     = data;
      load_done     = done;
      instr_ready   = 1'($urandom % 2);
      branch_valid  = 1'($urandom % 2);
      branch_target = AW'($urandom);
      @(negedge clock);
      checkOutput("load_we", iram_write_enable, 1);
      checkOutput("load_addr", iram_address, addr);
      checkOutput("load_valid_low", instr_valid, 0);
      @(posedge clock);
      #1;
      memModel[addr] = data;
      load_valid   = 1'b0;
      load_done    = 1'b0;
      branch_valid = 1'b0;
      if (done) resetModel();
   endtask

   // Drive one cycle of handshake/branch inputs and check the DUT against the model.
   task automatic applyStimulus(input bit rdy, input bit bv, input logic [AW-1:0] bt);
      instr_ready   = rdy;
      branch_valid  = bv;
      branch_target = bt;
      @(negedge clock);
      if (expHalted) begin
         checkOutput("halted_high", halted, 1);
         checkOutput("halt_valid_low", instr_valid, 0);
      end else begin
         checkOutput("halted_low", halted, 0);
         if (prevHold) begin
            checkOutput("hold_valid", instr_valid, 1);
            checkOutput("hold_data", instr_data, prevData);
            checkOutput("hold_pc", instr_pc, prevPc);
         end
         if (bv) begin
            gap   = 0;
            expPc = bt;
         end else if (instr_valid && rdy) begin
            gap = 0;
            checkOutput("deliver_pc", instr_pc, expPc);
            checkOutput("deliver_data", instr_data, memModel[expPc]);
            deliveredQ.push_back(int'(instr_pc));
            if (instr_data[31:26] == HALT_OPCODE) expHalted = 1'b1;
            expPc = expPc + 1'b1;
         end else if (!instr_valid) begin
            gap++;
         end
         checkOutput("no_stall", (gap > 1) ? 1 : 0, 0);
         prevHold = instr_valid && !rdy && !bv;
         prevData = instr_data;
         prevPc   = instr_pc;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic runUntilHalted(input int maxCycles, input bit randomReady);
      for (int i = 0; i < maxCycles; i++) begin
         if (expHalted) break;
         applyStimulus(randomReady ? ($urandom % 4 != 0) : 1'b1, 1'b0, '0);
      end
      checkOutput("halt_reached", expHalted, 1);
   endtask

   task automatic runUntilCount(input int n);
      for (int i = 0; i < 50; i++) begin
         if (deliveredQ.size() >= n) break;
         applyStimulus(1'b1, 1'b0, '0);
      end
      checkOutput("count_reached", (deliveredQ.size() >= n) ? 1 : 0, 1);
   endtask

   task automatic checkDelivered(input string tag);
      checkOutput({tag, "_len"}, deliveredQ.size(), expectQ.size());
      for (int i = 0; i < expectQ.size() && i < deliveredQ.size(); i++)
         checkOutput({tag, "_order"}, deliveredQ[i], expectQ[i]);
   endtask

   task automatic doReset();
      load_addr  = 10'h155;
      load_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_valid", instr_valid, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_data", instr_data, 0);
      checkOutput("rst_pc", instr_pc, 0);
      checkOutput("rst_addr", iram_address, 10'h155);
      checkOutput("rst_we", iram_write_enable, 0);
      @(posedge clock);
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      resetModel();
   endtask

   task automatic loadBasic();
      loadWord(0, {OP_ADD, 26'($urandom)}, 0);
      loadWord(1, {OP_SUB, 26'($urandom)}, 0);
      loadWord(2, {OP_SUBI, 26'($urandom)}, 0);
      loadWord(3, 32'hFC000000, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]      = '0;
         memModel[i] = '0;
      end
      @(posedge clock);
      #1;
      doReset();

      // Straight-line program ending in HALT, decode always ready.
      loadBasic();
      runUntilHalted(20, 1'b0);
      expectQ = '{0, 1, 2, 3};
      checkDelivered("basic");
      applyStimulus(1'($urandom % 2), 1'b1, 10'h010);
      applyStimulus(1'b1, 1'b0, '0);

      // Back-pressure while word 1 is held.
      doReset();
      loadBasic();
      runUntilCount(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, '0);
         checkOutput("stall_pc", iram_address, 2);
      end
      runUntilHalted(20, 1'b0);
      expectQ = '{0, 1, 2, 3};
      checkDelivered("stall");

      // Branch squashes the held word at pc 5 even with ready high.
      doReset();
      for (int a = 0; a < 8; a++) loadWord(AW'(a), randNonHalt(), 0);
      for (int a = 0; a < 3; a++) loadWord(AW'(10'h200 + a), randNonHalt(), 0);
      loadWord(10'h203, haltWord(), 1);
      runUntilCount(5);
      applyStimulus(1'b1, 1'b1, 10'h200);
      runUntilHalted(20, 1'b0);
      expectQ = '{0, 1, 2, 3, 4, 'h200, 'h201, 'h202, 'h203};
      checkDelivered("squash");

      // Wrap from the top address back to 0.
      doReset();
      loadWord(0, haltWord(), 0);
      loadWord(10'd1023, randNonHalt(), 1);
      applyStimulus(1'b1, 1'b1, 10'd1023);
      runUntilHalted(20, 1'b0);
      expectQ = '{1023, 0};
      checkDelivered("wrap");

      // Branch while draining cancels the halt.
      doReset();
      for (int a = 0; a < 3; a++) loadWord(AW'(a), randNonHalt(), 0);
      loadWord(3, haltWord(), 0);
      for (int a = 0; a < 4; a++) loadWord(AW'(10'h010 + a), randNonHalt(), 0);
      loadWord(10'h014, haltWord(), 1);
      runUntilCount(3);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 10'h010);
      runUntilHalted(30, 1'b0);
      expectQ = '{0, 1, 2, 'h10, 'h11, 'h12, 'h13, 'h14};
      checkDelivered("drain_branch");

      // Reset mid-run with a word held, then reload and refetch from 0.
      doReset();
      loadWord(10'h030, randNonHalt(), 1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
      checkOutput("pre_reset_valid", instr_valid, 1);
      doReset();
      loadWord(0, randNonHalt(), 1);
      runUntilCount(3);
      expectQ = '{0, 1, 2};
      checkDelivered("reload");

      // Randomized program, back-pressure and redirects.
      doReset();
      begin
         int haltAt;
         haltAt = ($urandom % 2 != 0) ? 40 + int'($urandom % 24) : 1000;
         for (int a = 0; a < 64; a++)
            loadWord(AW'(a), (a == haltAt) ? haltWord() : randNonHalt(), a == 63);
         for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] tgt;
            tgt = ($urandom % 8 == 0) ? AW'(1020 + ($urandom % 4)) : AW'($urandom % 64);
            applyStimulus($urandom % 4 != 0, $urandom % 12 == 0, tgt);
         end
         checkOutput("random_progress", (deliveredQ.size() > 0) ? 1 : 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequencer that owns the program counter and drives the instruction RAM. After reset it lets a host loader write the program into the RAM, then fetches one 32-bit instruction word per accepted handshake toward decode. It handles branch redirects and stops at a HALT opcode. It sits between the instruction RAM (combinational read, synchronous write) and the decode stage.

## Interface
- ADDR_WIDTH, 10, instruction RAM word-address width (1024 words)
- DATA_WIDTH, 32, instruction word width
- HALT_OPCODE, 6'b111111, opcode in bits [31:26] that ends execution
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- load_valid  in  1  host write strobe, honoured only in LOAD
- load_addr  in  ADDR_WIDTH  host write address
- load_data  in  DATA_WIDTH  host write data
- load_done  in  1  host finished; LOAD -> RUN
- iram_address  out  ADDR_WIDTH  RAM address (load_addr in LOAD, pc otherwise)
- iram_write_enable  out  1  RAM write strobe
- iram_write_data  out  DATA_WIDTH  RAM write data
- iram_data  in  DATA_WIDTH  RAM combinational read data at iram_address
- instr_valid  out  1  instr_data/instr_pc hold a fetched word
- instr_ready  in  1  decode accepts the word this cycle
- instr_data  out  DATA_WIDTH  fetched instruction
- instr_pc  out  ADDR_WIDTH  address the word was fetched from
- branch_valid  in  1  redirect request (single-cycle)
- branch_target  in  ADDR_WIDTH  redirect address
- halted  out  1  high in HALT state

## Operation
- States: LOAD (reset state), RUN, DRAIN, HALT.
- LOAD:
  - iram_address=load_addr, iram_write_enable=load_valid, iram_write_data=load_data.
  - instr_valid=0. Branches are ignored.
  - load_done=1: the write in the same cycle (if load_valid) still occurs; next state RUN, pc<=0.
- RUN:
  - iram_address=pc, iram_write_enable=0.
  - Fetch fires when (!instr_valid || instr_ready) && !branch_valid.
  - On fetch: output register <= {iram_data, pc}, instr_valid<=1, pc<=pc+1. pc wraps from 2^ADDR_WIDTH-1 to 0.
  - If the captured word's [31:26]==HALT_OPCODE: next state DRAIN, pc frozen.
  - Accept without fetch is impossible in RUN, because fetch has priority whenever the output frees.
- Branch (RUN or DRAIN, branch_valid=1):
  - pc<=branch_target; instr_valid<=0, squashing any held word even if instr_ready is also high.
  - No fetch in that cycle. Next state RUN. A branch in DRAIN cancels the pending halt.
- DRAIN: holds the HALT word until instr_ready, then instr_valid<=0 and next state HALT.
- HALT: halted=1, instr_valid=0. All inputs ignored; only reset exits.
- Reset values: state=LOAD, pc=0, instr_valid=0, instr_data=0, instr_pc=0, halted=0, iram_write_enable=0 (it follows load_valid combinationally in LOAD).
- Reset asserted mid-operation discards held words and pc. RAM contents are untouched.

## Timing
- Fetch latency 1 cycle: a fetch fired at edge N presents instr_valid after edge N.
- Throughput: one word per cycle while instr_ready=1.
- The first fetch fires on the first RUN cycle (the edge after load_done); instr_valid rises one cycle later.
- Branch penalty: the cycle with branch_valid plus one refetch cycle. The word from branch_target is valid 2 edges after the branch cycle.
- instr_data/instr_pc are stable while instr_valid && !instr_ready.
- Write-to-read: a word loaded in LOAD is readable from the first RUN cycle (RAM write is synchronous).

## Structure
- Shared package holds:
  - state encoding (LOAD, RUN, DRAIN, HALT)
  - HALT_OPCODE and opcode field bounds [31:26]
  - the ADD/SUB/SUBi opcode constants (000000/000010/000011)
- Single module, no sub-modules. The output register is inline; the RAM is instantiated beside it by the top level.

## Test plan
- Load words 0..2 = ADD, SUB, SUBi, word 3 = 32'hFC000000; load_done; instr_ready=1 -> pcs 0,1,2,3 delivered on consecutive cycles, then halted=1 one cycle after the HALT word is accepted.
- Same program with instr_ready low for 3 cycles while word 1 is held -> instr_data and instr_pc=1 stay stable; pc is not advanced past 2.
- branch_valid with target 0x200 while word at pc 5 is held and instr_ready=1 -> word 5 squashed (never accepted); next valid word has instr_pc=0x200.
- Load only address 1023 plus HALT at 0; run from a branch to 1023 -> delivery order 1023, 0, then HALT.
- Branch to 0x010 during DRAIN -> no halt; fetch resumes at 0x010.
- reset low mid-RUN with instr_valid=1 -> instr_valid=0, state LOAD, pc=0 immediately; a reload plus load_done refetches from 0.
